// File: rtl/alu_pipe_seq_pkg.sv
// Shared encodings for the pipelined ALU: op codes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_POS   = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_CARRY = 3;
  localparam int FLAG_OVF   = 4;
  localparam int FLAG_W     = 5;

endpackage

// File: rtl/alu_pipe_seq_if.sv
// Operand/result bus of the pipelined ALU; the ALU is the slave, decode/writeback the master.
interface alu_pipe_seq_if #(
  parameter int WIDTH = 16
) ();
  // Handshake: a transfer happens on a rising clk edge where valid & ready are both 1.
  // A producer holding valid keeps its payload stable until the transfer; ready may
  // depend combinationally on the consumer's ready, never on the producer's valid.
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             pos;
  logic             neg;
  logic             carry;
  logic             ovf;

  modport master (
    output in_valid, op, in0, in1, out_ready,
    input  in_ready, out_valid, out, zero, pos, neg, carry, ovf
  );

  modport slave (
    input  in_valid, op, in0, in1, out_ready,
    output in_ready, out_valid, out, zero, pos, neg, carry, ovf
  );
endinterface

// File: rtl/alu_pipe_seq_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles after start.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_product
);
  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;
  logic [2*WIDTH-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH - 1);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - 1'b1;
      if (r_cnt == '0) r_busy <= 1'b0;
    end
  end

  // The last partial product is summed combinationally so the caller can load it on the final busy edge.
  assign o_done    = r_busy && (r_cnt == '0);
  assign o_product = w_acc_next;

endmodule

// File: rtl/alu_pipe_seq.sv
// Registered ALU with valid/ready handshake, single-cycle ops and an optional multi-cycle multiply.
module alu_pipe_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  alu_pipe_seq_if.slave    bus,
  output state_t           o_state
);

  localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

  state_t              r_state;
  logic                r_valid;
  logic [WIDTH-1:0]    r_out;
  logic [FLAG_W-1:0]   r_flags;

  logic                w_accept;
  logic                w_mul_op;
  logic                w_mul_start;
  logic                w_mul_done;
  logic                w_mul_hi;
  logic [2*WIDTH-1:0]  w_mul_prod;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH-1:0]    w_res;
  logic                w_carry;
  logic                w_ovf;

  function automatic logic [FLAG_W-1:0] make_flags(input logic [WIDTH-1:0] res,
                                                   input logic c, input logic v);
    logic [FLAG_W-1:0] f;
    f             = '0;
    f[FLAG_ZERO]  = (res == '0);
    f[FLAG_NEG]   = res[WIDTH-1];
    f[FLAG_POS]   = (res != '0) && !res[WIDTH-1];
    f[FLAG_CARRY] = c;
    f[FLAG_OVF]   = v;
    return f;
  endfunction

  assign bus.in_ready = (r_state == S_IDLE) && (!r_valid || bus.out_ready);
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_mul_op     = (bus.op == OP_MUL) && (MUL_EN != 0);
  assign w_mul_start  = w_accept && w_mul_op;

  always_comb begin
    w_sum   = '0;
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        w_sum   = {1'b0, bus.in0} + {1'b0, bus.in1};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (bus.in0[WIDTH-1] == bus.in1[WIDTH-1]) && (w_res[WIDTH-1] != bus.in0[WIDTH-1]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        w_sum   = {1'b0, bus.in0} - {1'b0, bus.in1};
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
        w_ovf   = (bus.in0[WIDTH-1] != bus.in1[WIDTH-1]) && (w_res[WIDTH-1] != bus.in0[WIDTH-1]);
      end
      OP_AND: w_res = bus.in0 & bus.in1;
      OP_OR:  w_res = bus.in0 | bus.in1;
      OP_XOR: w_res = bus.in0 ^ bus.in1;
      OP_SLL: w_res = (bus.in1 >= SHIFT_LIMIT) ? '0 : (bus.in0 << bus.in1);
      OP_SRL: w_res = (bus.in1 >= SHIFT_LIMIT) ? '0 : (bus.in0 >> bus.in1);
      OP_MUL: w_ovf = 1'b1;
      default: w_res = '0;
    endcase
  end

  if (MUL_EN != 0) begin : g_mul
    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .reset     (reset),
      .i_start   (w_mul_start),
      .i_a       (bus.in0),
      .i_b       (bus.in1),
      .o_done    (w_mul_done),
      .o_product (w_mul_prod)
    );
  end else begin : g_no_mul
    assign w_mul_done = 1'b0;
    assign w_mul_prod = '0;
  end

  assign w_mul_hi = |w_mul_prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_mul_op) begin
            r_state <= S_MUL;
            r_valid <= 1'b0;
          end else if (w_accept) begin
            r_out   <= w_res;
            r_flags <= make_flags(w_res, w_carry, w_ovf);
            r_valid <= 1'b1;
          end else if (bus.out_ready) begin
            r_valid <= 1'b0;
          end
        end
        S_MUL: begin
          if (w_mul_done) begin
            r_out   <= w_mul_prod[WIDTH-1:0];
            r_flags <= make_flags(w_mul_prod[WIDTH-1:0], w_mul_hi, w_mul_hi);
            r_valid <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out       = r_out;
  assign bus.zero      = r_flags[FLAG_ZERO];
  assign bus.pos       = r_flags[FLAG_POS];
  assign bus.neg       = r_flags[FLAG_NEG];
  assign bus.carry     = r_flags[FLAG_CARRY];
  assign bus.ovf       = r_flags[FLAG_OVF];
  assign o_state       = r_state;

endmodule

// File: tb/tb_alu_pipe_seq.sv
// Bench for alu_pipe_seq: directed vectors plus random ops scored against an arithmetic reference model.
module tb_alu_pipe_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;

  alu_pipe_seq_if #(.WIDTH(W)) bus ();

  alu_pipe_seq #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset / sink ready ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic rand_ready   = 1'b0;
  logic forced_ready = 1'b1;
  logic r_rand       = 1'b1;
  always @(posedge clk) begin
    #1;
    r_rand = ($urandom_range(0, 3) != 0);
  end
  assign bus.out_ready = rand_ready ? r_rand : forced_ready;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard bookkeeping ----------------
  logic [W+4:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W+4:0] mk(input logic [W-1:0] r, input logic z, input logic p,
                                      input logic n, input logic c, input logic v);
    return {r, z, p, n, c, v};
  endfunction

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic logic [W+4:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned      ua;
    int unsigned      ub;
    int               sa;
    int               sb;
    int               sr;
    longint unsigned  p;
    logic [W-1:0]     r;
    logic             c;
    logic             v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = '0;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      3'd0: begin
        p  = longint'(ua) + longint'(ub);
        r  = p[W-1:0];
        c  = (p > 64'd65535);
        sr = sa + sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      3'd1: begin
        r  = a - b;
        c  = (ua < ub);
        sr = sa - sb;
        v  = (sr > 32767) || (sr < -32768);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (ub >= 16) ? 16'h0 : 16'(ua << ub);
      3'd6: r = (ub >= 16) ? 16'h0 : 16'(ua >> ub);
      default: begin
        p = longint'(ua) * longint'(ub);
        r = p[W-1:0];
        c = (p > 64'd65535);
        v = c;
      end
    endcase
    return mk(r, (r == 0), (r != 0) && !r[W-1], r[W-1], c, v);
  endfunction

  // ---------------- monitor ----------------
  wire [W+4:0] w_resp = {bus.out, bus.zero, bus.pos, bus.neg, bus.carry, bus.ovf};

  logic         held = 1'b0;
  logic [W+4:0] snap;
  logic [W+4:0] mon_exp;

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) check("hold_stable", bus.out_valid && (w_resp == snap), 32'(w_resp), 32'(snap));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1'b0, 32'(w_resp), 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", w_resp == mon_exp, 32'(w_resp), 32'(mon_exp));
        end
        held = 1'b0;
      end else if (bus.out_valid) begin
        check("hold_in_ready", bus.in_ready == 1'b0, 32'(bus.in_ready), 32'd0);
        held = 1'b1;
        snap = w_resp;
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int acc_cyc = 0;

  // Called at posedge+1; returns at posedge+1 of the accept edge so calls chain back-to-back.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W+4:0] e, input bit push);
    int n;
    n          = 0;
    bus.in_valid = 1'b1;
    bus.op     = op;
    bus.in0    = a;
    bus.in1    = b;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 1'b0, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) exp_q.push_back(e);
      #1;
      acc_cyc      = cyc;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           low;
    int           bad;
    int           t0;
    logic [2:0]   rop;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    bus.in_valid = 1'b0;
    bus.op       = 3'd0;
    bus.in0      = '0;
    bus.in1      = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", bus.out_valid == 1'b0, 32'(bus.out_valid), 32'd0);
    check("reset_outputs", w_resp == '0, 32'(w_resp), 32'd0);
    check("reset_state", dbg_state == S_IDLE, 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.in_ready == 1'b1, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors with hand-derived expectations
    send(OP_ADD, 16'h7FFF, 16'h0001, mk(16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 1'b1);
    @(negedge clk);
    check("add_latency", bus.out_valid == 1'b1, 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    send(OP_SUB, 16'd5, 16'd5, mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    send(OP_SUB, 16'd3, 16'd5, mk(16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), 1'b1);
    send(OP_SLL, 16'h0001, 16'd15, mk(16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    send(OP_SLL, 16'h0001, 16'd16, mk(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b1);
    send(OP_SRL, 16'h8000, 16'd15, mk(16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);

    send(OP_MUL, 16'd300, 16'd300, mk(16'h5F90, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1), 1'b1);
    low = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (!bus.in_ready && !bus.out_valid) low++;
    end
    check("mul_busy_cycles", low == 16, 32'(low), 32'd16);
    @(negedge clk);
    check("mul_latency", bus.out_valid == 1'b1, 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Output hold with the sink stalled, then a same-edge take-and-replace
    forced_ready = 1'b0;
    send(OP_ADD, 16'd1, 16'd2, mk(16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid_noready", bus.out_valid && !bus.in_ready && (bus.out == 16'h0003),
            32'({bus.out_valid, bus.in_ready, bus.out}), 32'({1'b1, 1'b0, 16'h0003}));
    end
    @(posedge clk);
    #1;
    forced_ready = 1'b1;
    send(OP_XOR, 16'hA5A5, 16'h5A5A, mk(16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 1'b1);
    @(negedge clk);
    check("replace_valid", bus.out_valid == 1'b1, 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops at full rate
    t0 = 0;
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 6));
      ra  = 16'($urandom);
      rb  = 16'($urandom_range(0, 18));
      send(rop, ra, rb, model(rop, ra, rb), 1'b1);
      if (i == 0) t0 = acc_cyc;
    end
    check("throughput", (acc_cyc - t0) == 7, 32'(acc_cyc - t0), 32'd7);

    // Reset in the middle of a multiply must abort it with no late result
    drain();
    send(OP_MUL, 16'd7, 16'd9, '0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", !bus.out_valid && (w_resp == '0), 32'({bus.out_valid, w_resp}), 32'd0);
    check("abort_state", dbg_state == S_IDLE, 32'(dbg_state), 32'(S_IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", bus.in_ready == 1'b1, 32'(bus.in_ready), 32'd1);
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    check("no_stale_result", bad == 0, 32'(bad), 32'd0);
    @(posedge clk);
    #1;

    // Random ops against the reference model with a randomly stalling sink
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ra = 16'h7FFF;
        1:       ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      if (rop == OP_SLL || rop == OP_SRL) rb = 16'($urandom_range(0, 20));
      else if ($urandom_range(0, 4) == 0)  rb = 16'hFFFF;
      else                                 rb = 16'($urandom);
      send(rop, ra, rb, model(rop, ra, rb), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rand_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
